// File: rtl/pipeline_hazard_controller_if.sv
// Hazard request / pipeline control bundle between the core datapath and the
// pipeline_hazard_controller.
//   load_use   : decode detected a load-use dependency
//   redirect   : execute resolved a PC redirect
//   mem_busy   : memory stage waiting on data memory
//   fetch_busy : instruction memory has no valid word
//   stall[k]   : hold pipeline register k (0=F/D, 1=D/E, 2=E/M, 3=M/W)
//   flush[k]   : load NOP into pipeline register k
// master = datapath side (raises requests), slave = controller side.
interface pipeline_hazard_controller_if #(
    parameter int unsigned NUM_STAGES = 5
);
    logic                  load_use;
    logic                  redirect;
    logic                  mem_busy;
    logic                  fetch_busy;
    logic [NUM_STAGES-2:0] stall;
    logic [NUM_STAGES-2:0] flush;

    modport master (
        output load_use, redirect, mem_busy, fetch_busy,
        input  stall, flush
    );

    modport slave (
        input  load_use, redirect, mem_busy, fetch_busy,
        output stall, flush
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush generator for the in-order core's pipeline registers.
// Outputs are Mealy (current state + inputs), so a request seen in cycle N
// takes effect at the clock edge ending cycle N. A small FSM with a
// down-counter stretches redirect flushes and load-use stalls over several
// cycles; a memory wait freezes whatever was in progress and resumes it.
// Ports:
//   clock        : core clock, rising edge
//   reset        : asynchronous, active-low
//   hz           : request/control bundle (slave side)
//   state        : RUN=0, HAZARD=1, FLUSH=2, MEM_WAIT=3
//   stall_cycles : saturating count of cycles with any stall bit set
//   scan         : enables capture of internals into the scan snapshot
module pipeline_hazard_controller #(
    parameter int unsigned CORE                = 0,
    parameter int unsigned NUM_STAGES          = 5,
    parameter int unsigned FLUSH_CYCLES        = 1,
    parameter int unsigned HAZARD_STALL_CYCLES = 1,
    parameter int unsigned SCAN_CYCLES_MIN     = 1,
    parameter int unsigned SCAN_CYCLES_MAX     = 1000
) (
    input  logic                         clock,
    input  logic                         reset,
    pipeline_hazard_controller_if.slave  hz,
    output logic [1:0]                   state,
    output logic [31:0]                  stall_cycles,
    input  logic                         scan
);

    localparam int unsigned NREG = NUM_STAGES - 1;
    localparam int unsigned T    = NUM_STAGES - 2;
    localparam int unsigned MAXC = (FLUSH_CYCLES > HAZARD_STALL_CYCLES) ?
                                   FLUSH_CYCLES : HAZARD_STALL_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);
    localparam int unsigned SW   = 8 + 2 + CW + 2 * NREG;

    localparam logic [NREG-1:0] ONE        = {{(NREG-1){1'b0}}, 1'b1};
    localparam logic [NREG-1:0] MEMP_STALL = (ONE << T) - ONE;
    localparam logic [NREG-1:0] MEMP_FLUSH = ONE << T;
    localparam logic [NREG-1:0] REDP_FLUSH = (ONE << 2) - ONE;
    localparam logic [NREG-1:0] LUP_STALL  = ONE;
    localparam logic [NREG-1:0] LUP_FLUSH  = ONE << 1;
    localparam logic [NREG-1:0] FETP_FLUSH = ONE;
    localparam logic [CW-1:0]   FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0]   HAZ_LOAD   = CW'(HAZARD_STALL_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StHazard  = 2'd1,
        StFlush   = 2'd2,
        StMemWait = 2'd3
    } state_e;

    state_e          state_q, state_d;
    state_e          resume_state_q, resume_state_d;
    state_e          eff_state;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   resume_cnt_q, resume_cnt_d;
    logic [CW-1:0]   eff_cnt;
    logic [NREG-1:0] stall_v, flush_v;
    logic [31:0]     stall_cycles_q;
    logic [31:0]     scan_cyc_q;
    logic            scan_hit;
    logic [SW-1:0]   scan_snap_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        resume_state_d = resume_state_q;
        resume_cnt_d   = resume_cnt_q;
        stall_v        = '0;
        flush_v        = '0;
        // While parked in MEM_WAIT, behave as the interrupted state.
        eff_state      = state_q;
        eff_cnt        = cnt_q;
        if (state_q == StMemWait) begin
            eff_state = resume_state_q;
            eff_cnt   = resume_cnt_q;
        end

        if (hz.mem_busy) begin
            stall_v = MEMP_STALL;
            flush_v = MEMP_FLUSH;
            state_d = StMemWait;
            if (state_q != StMemWait) begin
                resume_state_d = state_q;
                resume_cnt_d   = cnt_q;
            end
        end else begin
            state_d = eff_state;
            cnt_d   = eff_cnt;
            if (hz.redirect) begin
                // Same response from RUN, HAZARD and FLUSH (restart in FLUSH).
                flush_v = REDP_FLUSH;
                if (FLUSH_CYCLES > 1) begin
                    state_d = StFlush;
                    cnt_d   = FLUSH_LOAD;
                end else begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end else begin
                case (eff_state)
                    StHazard: begin
                        stall_v = LUP_STALL;
                        flush_v = LUP_FLUSH;
                        if (eff_cnt <= CNT_ONE) begin
                            state_d = StRun;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = eff_cnt - CNT_ONE;
                        end
                    end
                    StFlush: begin
                        // FLP and FETP both flush F/D; load_use is ignored here.
                        flush_v = FETP_FLUSH;
                        if (eff_cnt <= CNT_ONE) begin
                            state_d = StRun;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = eff_cnt - CNT_ONE;
                        end
                    end
                    default: begin
                        if (hz.load_use) begin
                            stall_v = LUP_STALL;
                            flush_v = LUP_FLUSH;
                            if (HAZARD_STALL_CYCLES > 1) begin
                                state_d = StHazard;
                                cnt_d   = HAZ_LOAD;
                            end
                        end else if (hz.fetch_busy) begin
                            flush_v = FETP_FLUSH;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= StRun;
            cnt_q          <= '0;
            resume_state_q <= StRun;
            resume_cnt_q   <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            resume_state_q <= resume_state_d;
            resume_cnt_q   <= resume_cnt_d;
            if (|stall_v && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
        end
    end

    // Scan: free-running cycle counter; inside the window the current
    // {CORE, state, cnt, stall, flush} is captured for debug probing.
    assign scan_hit = scan && (scan_cyc_q >= SCAN_CYCLES_MIN) &&
                      (scan_cyc_q <= SCAN_CYCLES_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scan_cyc_q  <= '0;
            scan_snap_q <= '0;
        end else begin
            scan_cyc_q  <= scan_cyc_q + 32'd1;
            scan_snap_q <= scan_hit ? {8'(CORE), state_q, cnt_q, stall_v, flush_v}
                                    : scan_snap_q;
        end
    end

    // Mealy outputs are forced quiet while reset is held, whatever the inputs.
    assign hz.stall     = reset ? stall_v : '0;
    assign hz.flush     = reset ? flush_v : '0;
    assign state        = state_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

    localparam int FC  = 2;
    localparam int HSC = 2;

    logic        clock;
    logic        reset;
    logic        scan;
    logic [1:0]  state;
    logic [31:0] stall_cycles;

    pipeline_hazard_controller_if #(.NUM_STAGES(5)) hz ();

    pipeline_hazard_controller #(
        .CORE               (0),
        .NUM_STAGES         (5),
        .FLUSH_CYCLES       (FC),
        .HAZARD_STALL_CYCLES(HSC),
        .SCAN_CYCLES_MIN    (1),
        .SCAN_CYCLES_MAX    (1000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .hz          (hz),
        .state       (state),
        .stall_cycles(stall_cycles),
        .scan        (scan)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles still owed to a flush burst / a load-use stall
    // burst, plus whether a memory wait is parking them.
    int          m_fl;
    int          m_hz;
    bit          m_wait;
    logic [31:0] m_cnt;

    task automatic model_reset();
        m_fl = 0; m_hz = 0; m_wait = 0; m_cnt = 0;
    endtask

    function automatic logic [1:0] model_state();
        if (m_wait)     return 2'd3;
        if (m_fl > 0)   return 2'd2;
        if (m_hz > 0)   return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_eval(input bit lu, input bit rd, input bit mb, input bit fb,
                              output logic [3:0] st, output logic [3:0] fl,
                              output int fl_n, output int hz_n, output bit wait_n);
        st = 4'b0; fl = 4'b0; fl_n = m_fl; hz_n = m_hz; wait_n = 1'b0;
        if (mb) begin
            st = 4'b0111; fl = 4'b1000; wait_n = 1'b1;
        end else if (rd) begin
            fl = 4'b0011; fl_n = FC - 1; hz_n = 0;
        end else if (m_fl > 0) begin
            fl = 4'b0001; fl_n = m_fl - 1;
        end else if (m_hz > 0) begin
            st = 4'b0001; fl = 4'b0010; hz_n = m_hz - 1;
        end else if (lu) begin
            st = 4'b0001; fl = 4'b0010; hz_n = HSC - 1;
        end else if (fb) begin
            fl = 4'b0001;
        end
    endtask

    // One clock cycle: drive at negedge, compare Mealy outputs and registered
    // state, then advance the model at the posedge.
    task automatic apply(input bit lu, input bit rd, input bit mb, input bit fb,
                         input bit use_tab, input logic [3:0] t_st, input logic [3:0] t_fl,
                         input logic [1:0] t_state);
        logic [3:0] e_st, e_fl;
        int fl_n, hz_n;
        bit wait_n;
        @(negedge clock);
        hz.load_use = lu; hz.redirect = rd; hz.mem_busy = mb; hz.fetch_busy = fb;
        scan = 1'($urandom_range(0, 1));
        #1;
        model_eval(lu, rd, mb, fb, e_st, e_fl, fl_n, hz_n, wait_n);
        if (use_tab) begin
            check("tab_stall", {28'b0, hz.stall}, {28'b0, t_st});
            check("tab_flush", {28'b0, hz.flush}, {28'b0, t_fl});
            check("tab_state", {30'b0, state}, {30'b0, t_state});
        end else begin
            check("rnd_stall", {28'b0, hz.stall}, {28'b0, e_st});
            check("rnd_flush", {28'b0, hz.flush}, {28'b0, e_fl});
            check("rnd_state", {30'b0, state}, {30'b0, model_state()});
        end
        check("stall_cycles", stall_cycles, m_cnt);
        check("no_overlap", {28'b0, hz.stall & hz.flush}, 32'd0);
        @(posedge clock);
        m_fl = fl_n; m_hz = hz_n; m_wait = wait_n;
        if (e_st != 4'b0 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    endtask

    typedef struct {
        bit         lu, rd, mb, fb;
        logic [3:0] st, fl;
        logic [1:0] state;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit lu, input bit rd, input bit mb, input bit fb,
                       input logic [3:0] st, input logic [3:0] fl, input logic [1:0] s);
        vec_t v;
        v.lu = lu; v.rd = rd; v.mb = mb; v.fb = fb; v.st = st; v.fl = fl; v.state = s;
        vecs.push_back(v);
    endtask

    initial begin
        // Directed sequence: {lu, rd, mb, fb} -> stall, flush, state this cycle.
        add(0, 0, 0, 0, 4'b0000, 4'b0000, 2'd0);
        add(1, 0, 0, 0, 4'b0001, 4'b0010, 2'd0); // load-use pulse
        add(0, 0, 0, 0, 4'b0001, 4'b0010, 2'd1);
        add(0, 0, 0, 0, 4'b0000, 4'b0000, 2'd0);
        add(0, 1, 0, 0, 4'b0000, 4'b0011, 2'd0); // redirect pulse
        add(1, 0, 0, 0, 4'b0000, 4'b0001, 2'd2); // load_use ignored in FLUSH
        add(0, 0, 0, 0, 4'b0000, 4'b0000, 2'd0);
        add(1, 0, 0, 0, 4'b0001, 4'b0010, 2'd0); // HAZARD then memory wait
        add(0, 0, 1, 0, 4'b0111, 4'b1000, 2'd1);
        add(0, 0, 1, 0, 4'b0111, 4'b1000, 2'd3);
        add(0, 0, 1, 0, 4'b0111, 4'b1000, 2'd3);
        add(0, 0, 0, 0, 4'b0001, 4'b0010, 2'd3); // resumes the owed LUP cycle
        add(0, 0, 0, 0, 4'b0000, 4'b0000, 2'd0);
        add(1, 1, 0, 1, 4'b0000, 4'b0011, 2'd0); // redirect wins
        add(0, 0, 0, 0, 4'b0000, 4'b0001, 2'd2);
        add(0, 1, 1, 0, 4'b0111, 4'b1000, 2'd0); // mem_busy wins
        add(0, 0, 0, 0, 4'b0000, 4'b0000, 2'd3);
        add(0, 0, 0, 1, 4'b0000, 4'b0001, 2'd0); // fetch bubble
        add(0, 1, 0, 0, 4'b0000, 4'b0011, 2'd0);
        add(0, 1, 0, 0, 4'b0000, 4'b0011, 2'd2); // redirect restarts FLUSH
        add(0, 0, 0, 1, 4'b0000, 4'b0001, 2'd2);
        add(0, 0, 0, 0, 4'b0000, 4'b0000, 2'd0);
        add(1, 0, 0, 0, 4'b0001, 4'b0010, 2'd0);
        add(0, 1, 0, 0, 4'b0000, 4'b0011, 2'd1); // redirect from HAZARD
        add(0, 0, 0, 0, 4'b0000, 4'b0001, 2'd2);
        add(0, 0, 0, 0, 4'b0000, 4'b0000, 2'd0);
        add(0, 1, 0, 0, 4'b0000, 4'b0011, 2'd0);
        add(0, 0, 1, 0, 4'b0111, 4'b1000, 2'd2); // wait interrupts FLUSH
        add(0, 0, 0, 0, 4'b0000, 4'b0001, 2'd3);
        add(0, 0, 0, 0, 4'b0000, 4'b0000, 2'd0);

        // Reset held low with random inputs.
        reset = 1'b0; scan = 1'b0;
        hz.load_use = 0; hz.redirect = 0; hz.mem_busy = 0; hz.fetch_busy = 0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            {hz.load_use, hz.redirect, hz.mem_busy, hz.fetch_busy} = 4'($urandom_range(1, 15));
            #1;
            check("rst_stall", {28'b0, hz.stall}, 32'd0);
            check("rst_flush", {28'b0, hz.flush}, 32'd0);
            check("rst_state", {30'b0, state}, 32'd0);
            check("rst_stall_cycles", stall_cycles, 32'd0);
        end
        @(negedge clock);
        {hz.load_use, hz.redirect, hz.mem_busy, hz.fetch_busy} = 4'b0;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) apply(0, 0, 0, 0, 1, 4'b0, 4'b0, 2'd0);

        foreach (vecs[i]) begin
            apply(vecs[i].lu, vecs[i].rd, vecs[i].mb, vecs[i].fb, 1,
                  vecs[i].st, vecs[i].fl, vecs[i].state);
        end

        // Asynchronous reset in the middle of a FLUSH burst.
        apply(0, 1, 0, 0, 1, 4'b0000, 4'b0011, 2'd0);
        @(negedge clock);
        hz.redirect = 1'b1; hz.mem_busy = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("async_state", {30'b0, state}, 32'd0);
        check("async_stall", {28'b0, hz.stall}, 32'd0);
        check("async_flush", {28'b0, hz.flush}, 32'd0);
        check("async_cnt", 32'(dut.cnt_q), 32'd0);
        check("async_stall_cycles", stall_cycles, 32'd0);
        @(negedge clock);
        hz.redirect = 1'b0; hz.mem_busy = 1'b0;
        reset = 1'b1;
        model_reset();
        apply(0, 0, 0, 0, 1, 4'b0, 4'b0, 2'd0);

        // Randomised run against the model.
        for (int i = 0; i < 1500; i++) begin
            apply(($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                  0, 4'b0, 4'b0, 2'd0);
        end

        // Saturation of the stall counter from a preloaded near-full value.
        @(negedge clock);
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles_q;
        m_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) apply(0, 0, 1, 0, 0, 4'b0, 4'b0, 2'd0);
        apply(0, 0, 0, 0, 0, 4'b0, 4'b0, 2'd0);
        check("saturated", stall_cycles, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
